// File: rtl/shift_rotate_pkg.sv
// Shared constants for the shift/rotate unit: opcode encodings, default width
// and opcode classification helpers.
package shift_rotate_pkg;

  localparam int SR_WIDTH = 8;

  localparam logic [2:0] OP_LSL = 3'b000;
  localparam logic [2:0] OP_LSR = 3'b001;
  localparam logic [2:0] OP_ASL = 3'b010;
  localparam logic [2:0] OP_ASR = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;

  // Opcodes 110/111 have no operation assigned and pass the operand through.
  function automatic logic sr_op_reserved(input logic [2:0] op);
    return (op == 3'b110) || (op == 3'b111);
  endfunction

endpackage

// File: rtl/shift_rotate_core.sv
// Combinational single-bit shift/rotate datapath: opcode selects the result
// and the bit shifted or rotated out.
module shift_rotate_core
  import shift_rotate_pkg::*;
#(
  parameter int WIDTH = SR_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  // Opcode decode; reserved codes fall to the pass-through default.
  always_comb begin
    result = a;
    carry  = 1'b0;
    case (opcode)
      OP_LSL, OP_ASL: begin
        result = {a[WIDTH-2:0], 1'b0};
        carry  = a[WIDTH-1];
      end
      OP_LSR: begin
        result = {1'b0, a[WIDTH-1:1]};
        carry  = a[0];
      end
      OP_ASR: begin
        result = {a[WIDTH-1], a[WIDTH-1:1]};
        carry  = a[0];
      end
      OP_ROL: begin
        result = {a[WIDTH-2:0], a[WIDTH-1]};
        carry  = a[WIDTH-1];
      end
      OP_ROR: begin
        result = {a[0], a[WIDTH-1:1]};
        carry  = a[0];
      end
      default: begin
        result = a;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_rotate.sv
// Registered shift/rotate unit: one-cycle latency, result/carry/zero held
// while no new operand is accepted.
module shift_rotate
  import shift_rotate_pkg::*;
#(
  parameter int WIDTH = SR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             out_valid
);

  logic [WIDTH-1:0] w_result;
  logic             w_carry;
  logic             w_zero;

  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_zero;
  logic             r_valid;

  shift_rotate_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (a),
    .opcode (opcode),
    .result (w_result),
    .carry  (w_carry)
  );

  assign w_zero = ~|w_result;

  // Output register stage; reset wins over a same-cycle operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= {WIDTH{1'b0}};
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_valid  <= 1'b0;
    end else if (in_valid) begin
      r_result <= w_result;
      r_carry  <= w_carry;
      r_zero   <= w_zero;
      r_valid  <= 1'b1;
    end else begin
      r_valid  <= 1'b0;
    end
  end

  assign result    = r_result;
  assign carry_out = r_carry;
  assign zero      = r_zero;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_shift_rotate.sv
// Directed and randomized bench for shift_rotate using an expected-result queue.
module tb_shift_rotate;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] a;
  logic [2:0] opcode;
  logic [7:0] result;
  logic       carry_out;
  logic       zero;
  logic       out_valid;

  typedef struct packed {
    logic [7:0] res;
    logic       c;
    logic       z;
  } exp_t;

  exp_t q[$];
  exp_t held;
  logic exp_valid;
  int   n_tests;
  int   n_fail;

  shift_rotate dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .opcode    (opcode),
    .result    (result),
    .carry_out (carry_out),
    .zero      (zero),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic reference, independent of bit-slicing.
  function automatic exp_t ref_op(input logic [7:0] av, input logic [2:0] op);
    int   v;
    exp_t e;
    v = av;
    case (op)
      3'd0, 3'd2: begin e.res = 8'((v * 2) % 256); e.c = (v >= 128); end
      3'd1:       begin e.res = 8'(v / 2);         e.c = (v % 2 == 1); end
      3'd3:       begin e.res = 8'(v / 2 + ((v >= 128) ? 128 : 0)); e.c = (v % 2 == 1); end
      3'd4:       begin e.res = 8'((v * 2) % 256 + v / 128); e.c = (v >= 128); end
      3'd5:       begin e.res = 8'(v / 2 + (v % 2) * 128); e.c = (v % 2 == 1); end
      default:    begin e.res = av; e.c = 1'b0; end
    endcase
    e.z = (e.res == 8'd0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: drive at negedge, check #1 after the rising edge.
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [7:0] av, input logic [2:0] op,
                      input logic [7:0] er, input logic ec);
    exp_t e;
    @(negedge clk);
    rst = r; in_valid = v; a = av; opcode = op;
    if (r) begin
      q.delete();
      held = '0;
      exp_valid = 1'b0;
    end else if (v) begin
      e.res = er; e.c = ec; e.z = (er == 8'd0);
      q.push_back(e);
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, 32'(out_valid), 32'(exp_valid));
    if (out_valid === 1'b1) begin
      n_tests++;
      assert (q.size() > 0) else begin
        n_fail++;
        $error("FAIL %s.queue observed=empty expected=entry", tag);
      end
      if (q.size() > 0) held = q.pop_front();
    end
    chk({tag, ".result"}, 32'(result), 32'(held.res));
    chk({tag, ".carry"}, 32'(carry_out), 32'(held.c));
    chk({tag, ".zero"}, 32'(zero), 32'(held.z));
  endtask

  initial begin
    exp_t   e;
    logic [7:0] ra;
    logic [2:0] rop;
    n_tests = 0; n_fail = 0;
    held = '0; exp_valid = 1'b0;
    rst = 1'b1; in_valid = 1'b0; a = 8'h00; opcode = 3'd0;

    step("rst0", 1'b1, 1'b1, 8'hFF, 3'd0, 8'h00, 1'b0);
    step("rst1", 1'b1, 1'b1, 8'hFF, 3'd0, 8'h00, 1'b0);

    step("lsl", 1'b0, 1'b1, 8'b10110101, 3'd0, 8'b01101010, 1'b1);
    step("lsr", 1'b0, 1'b1, 8'b10110101, 3'd1, 8'b01011010, 1'b1);
    step("asl", 1'b0, 1'b1, 8'b10110101, 3'd2, 8'b01101010, 1'b1);
    step("asr", 1'b0, 1'b1, 8'b10110101, 3'd3, 8'b11011010, 1'b1);
    step("rol", 1'b0, 1'b1, 8'b10110101, 3'd4, 8'b01101011, 1'b1);
    step("ror", 1'b0, 1'b1, 8'b10110101, 3'd5, 8'b11011010, 1'b1);

    step("asr_pos", 1'b0, 1'b1, 8'b01000000, 3'd3, 8'b00100000, 1'b0);
    step("lsl_zero", 1'b0, 1'b1, 8'b10000000, 3'd0, 8'b00000000, 1'b1);
    step("lsr_zero", 1'b0, 1'b1, 8'b00000001, 3'd1, 8'b00000000, 1'b1);

    step("rsv6", 1'b0, 1'b1, 8'hB5, 3'd6, 8'hB5, 1'b0);
    step("rsv7", 1'b0, 1'b1, 8'hB5, 3'd7, 8'hB5, 1'b0);

    step("rol81", 1'b0, 1'b1, 8'h81, 3'd4, 8'h03, 1'b1);
    step("hold0", 1'b0, 1'b0, 8'h00, 3'd1, 8'h00, 1'b0);
    step("hold1", 1'b0, 1'b0, 8'hFF, 3'd5, 8'h00, 1'b0);
    step("hold2", 1'b0, 1'b0, 8'h5A, 3'd0, 8'h00, 1'b0);

    step("mid_a", 1'b0, 1'b1, 8'hC3, 3'd1, 8'h61, 1'b1);
    step("mid_b", 1'b0, 1'b1, 8'hC3, 3'd4, 8'h87, 1'b1);
    step("mid_rst", 1'b1, 1'b1, 8'hC3, 3'd5, 8'h00, 1'b0);
    step("resume", 1'b0, 1'b1, 8'h3C, 3'd5, 8'h1E, 1'b0);
    step("idle", 1'b0, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0);

    for (int i = 0; i < 16; i++) begin
      ra  = 8'($urandom_range(0, 255));
      rop = 3'($urandom_range(0, 7));
      e = ref_op(ra, rop);
      step("rand", 1'b0, ($urandom_range(0, 3) != 0), ra, rop, e.res, e.c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
